pc_target_table: RTL

Runtime-programmable branch target table for the single-cycle/multicycle core's fetch stage. It is the parametrised successor to the fixed 8-entry hard-wired target lookup: depth and PC width are parameters, entries are written at runtime, and each entry is tagged absolute or PC-relative. Lookups are registered and return the resolved next-PC one cycle later. A post-reset sweep clears every entry before the table accepts traffic.

---
 rtl/pc_target_table.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pc_target_table.sv
// pc_target_table: runtime-programmable branch target table for the fetch stage.
// Each entry holds a D-bit value, a PC-relative flag and a programmed flag.
// Lookups are registered, so the resolved next-PC appears one cycle after the request.
// After reset, an init sweep clears the programmed flag of every entry.
// Handshake: there is no backpressure. A lookup or write is accepted on any edge
// where the table is READY and Reset is high. valid pulses for exactly one cycle
// per accepted lookup, and the consumer must take target/miss in that cycle.
module pc_target_table #(
    parameter int D = 12,
    parameter int N = 8,
    parameter int A = $clog2(N)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         lookup,
    input  logic [A-1:0] how_high,
    input  logic [D-1:0] pc,
    input  logic         wr_en,
    input  logic [A-1:0] wr_idx,
    input  logic [D-1:0] wr_target,
    input  logic         wr_rel,
    output logic [D-1:0] target,
    output logic         valid,
    output logic         miss,
    output logic         busy,
    output logic         state_dbg
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] cnt_q, cnt_d;

    logic [D-1:0] val_q [N];
    logic [N-1:0] rel_q;
    logic [N-1:0] vld_q;

    logic [D-1:0] target_q, target_d;
    logic         miss_q;
    logic         valid_q;

    logic         wr_accept;
    logic         lk_accept;
    logic         bypass;
    logic [D-1:0] sel_val;
    logic         sel_rel;
    logic         sel_vld;

    // Requests are honoured only once the sweep has finished and reset is released.
    assign wr_accept = Reset && (state_q == READY) && wr_en;
    assign lk_accept = Reset && (state_q == READY) && lookup;

    // State register and sweep counter. Reset restarts the sweep from entry 0.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: walk every entry once, then serve traffic until the next reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == A'(N - 1)) begin
                state_d = READY;
            end
        end
    end

    // Entry payload storage. It needs no reset because the programmed flag gates its use.
    always_ff @(posedge Clk) begin
        if (wr_accept) begin
            val_q[wr_idx] <= wr_target;
            rel_q[wr_idx] <= wr_rel;
        end
    end

    // Programmed flags: cleared one per cycle by the sweep, set by accepted writes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (state_q == INIT) begin
                vld_q[cnt_q] <= 1'b0;
            end else if (wr_accept) begin
                vld_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Entry select with write-first bypass, then resolve absolute or PC-relative targets.
    // A relative sum wraps modulo 2^D, so the signed offset needs no sign extension.
    always_comb begin
        bypass   = wr_accept && (wr_idx == how_high);
        sel_val  = bypass ? wr_target : val_q[how_high];
        sel_rel  = bypass ? wr_rel    : rel_q[how_high];
        sel_vld  = bypass ? 1'b1      : vld_q[how_high];
        target_d = '0;
        if (sel_vld) begin
            target_d = sel_rel ? (pc + sel_val) : sel_val;
        end
    end

    // Result registers: valid pulses per accepted lookup; target and miss hold otherwise.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            target_q <= '0;
            miss_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= lk_accept;
            if (lk_accept) begin
                target_q <= target_d;
                miss_q   <= !sel_vld;
            end
        end
    end

    assign target    = target_q;
    assign miss      = miss_q;
    assign valid     = valid_q;
    assign busy      = (state_q == INIT);
    assign state_dbg = state_q;

endmodule
